// File: rtl/tx_pkg.sv
// Shared types for the multi-source UART transmit stage.
//   byte_t     : one payload byte
//   tx_state_t : serializer FSM states
package tx_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART frame serializer with a ready/valid load port.
// Frames are 1 start bit, 8 data bits LSB first, an optional even parity bit
// and STOP_BITS stop bits. Every bit is held for 2*CLK_PER_HALF_BIT cycles.
// Optional feature macro: TX_PARITY_EN (inserts the PARITY state).
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-low reset
//   in_valid  : a byte is available to load
//   in_data   : byte to load
//   in_ready  : byte is taken this cycle (pop strobe)
//   txd       : serial output, idle high
//   idle      : FSM is in IDLE
//
// state  | meaning
// IDLE   | line idle, waiting for a byte
// LOAD   | pop the byte from the source and latch it
// START  | drive start bit (0)
// DATA   | drive data bits, LSB first
// PARITY | drive even parity of the latched byte
// STOP   | drive stop bit(s) (1); chain straight into LOAD if more data waits
module uart_tx_serializer
  import tx_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int STOP_BITS        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       txd,
  output logic       idle
);

  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] RELOAD    = CW'(BIT_CYC - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          stop_idx_q, stop_idx_d;
  byte_t         byte_q, byte_d;
  logic          bit_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      byte_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      byte_q     <= byte_d;
    end
  end

  // The counter is reloaded whenever a bit ends, so terminal count marks
  // the last cycle of the current bit.
  assign bit_done = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    byte_d     = byte_q;
    in_ready   = 1'b0;
    txd        = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        byte_d   = in_data;
        cnt_d    = RELOAD;
        state_d  = START;
      end
      START: begin
        txd = 1'b0;
        if (bit_done) begin
          cnt_d     = RELOAD;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        txd = byte_q[bit_idx_q];
        if (bit_done) begin
          cnt_d = RELOAD;
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
`ifdef TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PARITY: begin
        txd = ^byte_q;
        if (bit_done) begin
          cnt_d      = RELOAD;
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        txd = 1'b1;
        if (bit_done) begin
          if (stop_idx_q == LAST_STOP) begin
            state_d = in_valid ? LOAD : IDLE;
          end else begin
            stop_idx_d = 1'b1;
            cnt_d      = RELOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle = (state_q == IDLE);

endmodule

// File: rtl/tx_arbiter_uart.sv
// Multi-source UART output stage: fixed-priority arbitration of byte writes
// from N_SRC producers into a FIFO, serialised onto txd.
// Optional feature macro: TX_PARITY_EN (even parity bit after the data bits).
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-low reset
//   wr_en    : per-source write request, held until accepted
//   wr_data  : per-source byte, source i at [8*i+7:8*i]
//   stall    : source i requested but was not accepted this cycle
//   txd      : UART serial out, idle high
//   io_end   : every accepted byte has fully left the pin (registered)
//   level    : current FIFO occupancy
module tx_arbiter_uart
  import tx_pkg::*;
#(
  parameter int N_SRC            = 2,
  parameter int DEPTH            = 16384,
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int STOP_BITS        = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       wr_en,
  input  logic [8*N_SRC-1:0]     wr_data,
  output logic [N_SRC-1:0]       stall,
  output logic                   txd,
  output logic                   io_end,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [N_SRC-1:0] grant, accept;
  logic             push, pop, full, empty;
  byte_t            push_data, pop_data;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             sent_any_q, sent_any_d;
  logic             io_end_q, io_end_d;
  logic             ser_ready, ser_idle;
  byte_t            mem_q [DEPTH];

  // Isolate the lowest set request bit: index 0 has highest priority.
  assign grant  = wr_en & (~wr_en + N_SRC'(1));
  assign full   = (count_q == LW'(DEPTH));
  assign empty  = (count_q == '0);
  assign accept = full ? '0 : grant;
  assign stall  = wr_en & ~accept;
  assign push   = |accept;
  assign pop    = ser_ready & ~empty;

  always_comb begin
    push_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) push_data = wr_data[8*i +: 8];
    end
  end

  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    sent_any_d = sent_any_q | pop;
    // A pending request also blocks io_end, so it drops the cycle after an accept.
    io_end_d   = sent_any_q & empty & ser_idle & ~|wr_en;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sent_any_q <= 1'b0;
      io_end_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sent_any_q <= sent_any_d;
      io_end_q   <= io_end_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  uart_tx_serializer #(
    .CLK_PER_HALF_BIT (CLK_PER_HALF_BIT),
    .STOP_BITS        (STOP_BITS)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .in_valid (~empty),
    .in_data  (pop_data),
    .in_ready (ser_ready),
    .txd      (txd),
    .idle     (ser_idle)
  );

  assign io_end = io_end_q;
  assign level  = count_q;

endmodule
